dmem_unit: RTL and testbench
============================

Name: dmem_unit

Overview:
Parametrised big-endian, byte-addressed data memory for the core's MEM stage. It succeeds the flat byte RAM and adds:
- a valid/ready request handshake with a registered one-cycle response;
- sign- and zero-extending loads;
- misalignment and out-of-range fault reporting;
- a sequential clear-after-reset state machine.

Parameters:
ADDR_W, 32, request address width in bits.
DEPTH_BYTES, 4096, memory size in bytes; must be a power of two and a multiple of 4.
CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = keep contents and skip the clear.

Ports:
CLK  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request this cycle
memread  in  1  request is a load
memwrite  in  1  request is a store
addr  in  ADDR_W  byte address
write_data  in  32  store data; the low bytes are used for B/H
storeops  in  2  STORE_B / STORE_H / STORE_W
loadops  in  3  LOAD_B / LOAD_H / LOAD_W / LOAD_BU / LOAD_HU
resp_valid  out  1  response pulse
read_data  out  32  extended load result; 0 for stores and faults
resp_err  out  1  request faulted; nothing was written

Behaviour:
- Reset (async assert): state=CLEAR (or READY if CLEAR_ON_RESET=0), clr_cnt=0, req_ready=0, resp_valid=0, read_data=0, resp_err=0. An in-flight response is dropped.
- CLEAR state:
  - Each cycle, write 4 zero bytes at word index clr_cnt, then increment clr_cnt.
  - Takes DEPTH_BYTES/4 cycles; go to READY after the last word.
  - req_ready=0 throughout.
- READY state: req_ready=1; a request is accepted on a CLK edge when req_valid && req_ready.
- Byte order is big-endian. A word at A is {m[A], m[A+1], m[A+2], m[A+3]}.
  - Half store writes m[A]=wd[15:8], m[A+1]=wd[7:0].
  - Byte store writes m[A]=wd[7:0].
- Fault conditions (resp_err=1, no array write, read_data=0):
  - memread && memwrite both set;
  - H access with A[0]!=0;
  - W access with A[1:0]!=0;
  - A+size-1 >= DEPTH_BYTES;
  - undefined storeops or loadops encoding.
  - Access size is taken from storeops for stores and loadops for loads.
- Store: array updated at the accept edge. Next cycle resp_valid=1, resp_err=0, read_data=0.
- Load: array read at the accept edge (read-before-write is irrelevant; one request per cycle).
  - Next cycle resp_valid=1 and read_data is extended:
    - LOAD_B / LOAD_H: sign-extend from bit 7 / bit 15;
    - LOAD_BU / LOAD_HU: zero-extend;
    - LOAD_W: raw word.
- Neither memread nor memwrite with req_valid: accepted as a no-op. Next cycle resp_valid=1, err=0, data=0.
- Latency and throughput:
  - resp_valid is a one-cycle pulse, exactly 1 cycle after accept.
  - Back-to-back requests are accepted every cycle; throughput is 1/cycle.
- Response hold: read_data and resp_err hold their last values while resp_valid=0.
- Store-then-load to the same address on consecutive cycles: the load returns the new data.
- Address wrap: none. Any address >= DEPTH_BYTES faults; there is no aliasing.
- Reset during CLEAR restarts the clear from word 0.

Decomposition:
- Shared defs package holds STORE_B/H/W (2-bit, 2'b00 unused) and LOAD_B/H/W/BU/HU (3-bit), plus FSM state constants ST_CLEAR and ST_READY.
- One sub-module, dmem_load_ext: combinational word→byte/half select by addr[1:0] plus sign/zero extension.

Test Plan:
1. Reset with DEPTH_BYTES=64, CLEAR_ON_RESET=1 -> req_ready=0 for exactly 16 cycles, then 1; LOAD_W at 0x3C returns 0x00000000.
2. STORE_W 0x80FF7F01 @0x10, then loads @0x10 -> LOAD_W 0x80FF7F01; LOAD_B 0xFFFFFF80; LOAD_BU 0x00000080; LOAD_H @0x12 0x00007F01; LOAD_HU @0x10 0x000080FF.
3. STORE_H 0xABCD1234 @0x06, then LOAD_W @0x04 -> 0x00001234 (bytes 4,5 unchanged at 0); STORE_B 0x5A @0x07 then LOAD_W @0x04 -> 0x0000125A.
4. STORE_W @0x02, LOAD_H @0x01, LOAD_W @DEPTH_BYTES -> each gives resp_err=1, read_data=0; subsequent LOAD_W @0x00 shows no change.
5. req_valid held for 3 cycles (store @0x20, load @0x20, load @0x20) -> resp_valid high for 3 consecutive cycles; both loads return the stored word.
6. Assert reset mid-CLEAR at cycle 5 and release -> clear restarts; req_ready rises 16 cycles after release; a pending response is dropped.

Source files
------------

// File: rtl/dmem_unit_pkg.sv
// Shared definitions for the MEM-stage data memory: store/load op encodings,
// controller states and access-size helpers.
package dmem_unit_pkg;

    localparam logic [1:0] STORE_B = 2'b01;
    localparam logic [1:0] STORE_H = 2'b10;
    localparam logic [1:0] STORE_W = 2'b11;

    localparam logic [2:0] LOAD_B  = 3'b000;
    localparam logic [2:0] LOAD_H  = 3'b001;
    localparam logic [2:0] LOAD_W  = 3'b010;
    localparam logic [2:0] LOAD_BU = 3'b100;
    localparam logic [2:0] LOAD_HU = 3'b101;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Access size in bytes; 0 marks an undefined encoding.
    function automatic logic [2:0] store_size(input logic [1:0] op);
        case (op)
            STORE_B: return 3'd1;
            STORE_H: return 3'd2;
            STORE_W: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] load_size(input logic [2:0] op);
        case (op)
            LOAD_B, LOAD_BU: return 3'd1;
            LOAD_H, LOAD_HU: return 3'd2;
            LOAD_W:          return 3'd4;
            default:         return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Picks the addressed byte/half out of a big-endian word and sign- or
// zero-extends it according to the load op.
module dmem_load_ext
    import dmem_unit_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  loadops_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (off_i)
            2'd0:    byte_sel = word_i[31:24];
            2'd1:    byte_sel = word_i[23:16];
            2'd2:    byte_sel = word_i[15:8];
            default: byte_sel = word_i[7:0];
        endcase
        half_sel = off_i[1] ? word_i[15:0] : word_i[31:16];

        case (loadops_i)
            LOAD_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
            LOAD_BU: data_o = {24'd0, byte_sel};
            LOAD_H:  data_o = {{16{half_sel[15]}}, half_sel};
            LOAD_HU: data_o = {16'd0, half_sel};
            LOAD_W:  data_o = word_i;
            default: data_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/dmem_unit.sv
// Big-endian byte-addressed data memory with valid/ready requests, one-cycle
// registered responses, fault reporting and a word-at-a-time clear after reset.
module dmem_unit
    import dmem_unit_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DEPTH_BYTES    = 4096,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       write_data,
    input  logic [1:0]        storeops,
    input  logic [2:0]        loadops,
    output logic              resp_valid,
    output logic [31:0]       read_data,
    output logic              resp_err
);

    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [ADDR_W:0]  DEPTH_L   = (ADDR_W+1)'(DEPTH_BYTES);
    localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(WORDS - 1);

    state_e           state_q;
    logic [IDX_W-1:0] clr_cnt_q;
    logic             req_ready_q;
    logic             resp_valid_q;
    logic             resp_err_q;
    logic             load_ok_q;
    logic [2:0]       loadops_q;
    logic [1:0]       off_q;

    logic             accept;
    logic             is_mem;
    logic [2:0]       req_size;
    logic [ADDR_W:0]  end_addr;
    logic             fault;
    logic             do_store;
    logic             do_load;
    logic             clr_en;
    logic [IDX_W-1:0] widx;
    logic [3:0]       lane_we;
    logic [7:0]       lane_wd [4];
    logic [31:0]      rd_word;
    logic [31:0]      ext_data;

    assign accept   = req_valid && req_ready_q;
    assign is_mem   = memread || memwrite;
    assign req_size = memwrite ? store_size(storeops) : load_size(loadops);
    assign end_addr = {1'b0, addr} + (ADDR_W+1)'(req_size) - (ADDR_W+1)'(1);
    assign widx     = addr[IDX_W+1:2];
    assign clr_en   = (state_q == ST_CLEAR);

    // Any range/alignment check is meaningless for a no-op, so only memory ops can fault.
    assign fault = is_mem && ((memread && memwrite) ||
                              (req_size == 3'd0) ||
                              (req_size == 3'd2 && addr[0]) ||
                              (req_size == 3'd4 && addr[1:0] != 2'b00) ||
                              (end_addr >= DEPTH_L));

    assign do_store = accept && memwrite && !fault;
    assign do_load  = accept && memread && !fault;

    // Lane 0 holds the most significant byte of each word (big-endian).
    always_comb begin
        for (int ln = 0; ln < 4; ln++) begin
            lane_we[ln] = 1'b0;
            lane_wd[ln] = 8'd0;
            case (storeops)
                STORE_B: begin
                    lane_we[ln] = (ln == int'(addr[1:0]));
                    lane_wd[ln] = write_data[7:0];
                end
                STORE_H: begin
                    lane_we[ln] = ((ln / 2) == int'(addr[1]));
                    lane_wd[ln] = (ln % 2 == 1) ? write_data[7:0] : write_data[15:8];
                end
                STORE_W: begin
                    lane_we[ln] = 1'b1;
                    lane_wd[ln] = write_data[31-8*ln -: 8];
                end
                default: ;
            endcase
            lane_we[ln] = lane_we[ln] && do_store;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem_q [WORDS];
        logic [7:0] rd_byte_q;

        always_ff @(posedge CLK) begin
            if (clr_en) begin
                mem_q[clr_cnt_q] <= 8'd0;
            end else if (lane_we[gi]) begin
                mem_q[widx] <= lane_wd[gi];
            end
            if (do_load) begin
                rd_byte_q <= mem_q[widx];
            end
        end
    end

    assign rd_word = {g_lane[0].rd_byte_q, g_lane[1].rd_byte_q,
                      g_lane[2].rd_byte_q, g_lane[3].rd_byte_q};

    dmem_load_ext u_load_ext (
        .word_i    (rd_word),
        .off_i     (off_q),
        .loadops_i (loadops_q),
        .data_o    (ext_data)
    );

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clr_cnt_q    <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            load_ok_q    <= 1'b0;
            loadops_q    <= LOAD_W;
            off_q        <= 2'b00;
        end else begin
            resp_valid_q <= accept;
            // Response fields only move on accept so they hold between pulses.
            if (accept) begin
                resp_err_q <= fault;
                load_ok_q  <= do_load;
                loadops_q  <= loadops;
                off_q      <= addr[1:0];
            end
            case (state_q)
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + IDX_W'(1);
                    if (clr_cnt_q == LAST_WORD) begin
                        state_q     <= ST_READY;
                        req_ready_q <= 1'b1;
                    end
                end
                default: req_ready_q <= 1'b1;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign read_data  = load_ok_q ? ext_data : 32'd0;

endmodule

// File: tb/tb_dmem_unit.sv
// Scoreboard bench for dmem_unit: directed cases plus random traffic checked
// against a byte-array reference model.
module tb_dmem_unit;
    import dmem_unit_pkg::*;

    localparam int AW    = 32;
    localparam int DEPTH = 64;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        memread = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] write_data = '0;
    logic [1:0]  storeops = STORE_W;
    logic [2:0]  loadops = LOAD_W;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] read_data;
    logic        resp_err;

    dmem_unit #(.ADDR_W(AW), .DEPTH_BYTES(DEPTH), .CLEAR_ON_RESET(1)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .memread    (memread),
        .memwrite   (memwrite),
        .addr       (addr),
        .write_data (write_data),
        .storeops   (storeops),
        .loadops    (loadops),
        .resp_valid (resp_valid),
        .read_data  (read_data),
        .resp_err   (resp_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } resp_t;

    int          checks = 0;
    int          errors = 0;
    resp_t       exp_q[$];
    resp_t       mon_e;
    logic        last_err = 1'b0;
    logic [31:0] last_data = '0;
    logic [7:0]  ref_mem [DEPTH];

    // Reference: size from op, fault rules, big-endian byte-by-byte access.
    function automatic void model(input logic rd, input logic wr, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [1:0] sop,
                                  input logic [2:0] lop, output logic err,
                                  output logic [31:0] data);
        int          size;
        logic [63:0] last_byte;
        logic [31:0] w;
        err  = 1'b0;
        data = '0;
        if (!rd && !wr) return;
        if (wr) size = (sop == STORE_B) ? 1 : (sop == STORE_H) ? 2 : (sop == STORE_W) ? 4 : 0;
        else    size = (lop == LOAD_B || lop == LOAD_BU) ? 1 :
                       (lop == LOAD_H || lop == LOAD_HU) ? 2 : (lop == LOAD_W) ? 4 : 0;
        last_byte = 64'(a) + 64'(size) - 64'd1;
        if ((rd && wr) || size == 0 || (size == 2 && a % 2 != 0) ||
            (size == 4 && a % 4 != 0) || last_byte >= 64'(DEPTH)) begin
            err = 1'b1;
            return;
        end
        if (wr) begin
            for (int i = 0; i < size; i++) ref_mem[a + i] = 8'(wd >> (8 * (size - 1 - i)));
        end else begin
            w = '0;
            for (int i = 0; i < size; i++) w = (w << 8) | 32'(ref_mem[a + i]);
            if (lop == LOAD_B && w[7])  w = w | 32'hFFFF_FF00;
            if (lop == LOAD_H && w[15]) w = w | 32'hFFFF_0000;
            data = w;
        end
    endfunction

    task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] sop, input logic [2:0] lop,
                         input bit use_exp, input logic e_err, input logic [31:0] e_data);
        int          n;
        logic        m_err;
        logic [31:0] m_data;
        resp_t       r;
        n = 0;
        while (!req_ready && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: req_ready=%0b required 1", req_ready);
            return;
        end
        req_valid = 1'b1; memread = rd; memwrite = wr; addr = a;
        write_data = wd; storeops = sop; loadops = lop;
        @(posedge CLK); #1;
        model(rd, wr, a, wd, sop, lop, m_err, m_data);
        if (use_exp) begin r.err = e_err; r.data = e_data; end
        else         begin r.err = m_err; r.data = m_data; end
        exp_q.push_back(r);
    endtask

    task automatic idle();
        req_valid = 1'b0; memread = 1'b0; memwrite = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %08h required %08h", name, act, req);
        end
    endtask

    task automatic count_clear(input string name);
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        check(name, 32'(n), 32'd16);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'd0;
    endtask

    always @(negedge CLK) begin
        if (reset) begin
            last_err  = 1'b0;
            last_data = '0;
        end else if (resp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: got err=%0b data=%08h required no response",
                         resp_err, read_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (resp_err !== mon_e.err || read_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL resp: got err=%0b data=%08h required err=%0b data=%08h",
                             resp_err, read_data, mon_e.err, mon_e.data);
                end else begin
                    $display("resp ok: err=%0b data=%08h", resp_err, read_data);
                end
                last_err  = mon_e.err;
                last_data = mon_e.data;
            end
        end else begin
            checks++;
            if (resp_err !== last_err || read_data !== last_data) begin
                errors++;
                $display("FAIL hold: got err=%0b data=%08h required err=%0b data=%08h",
                         resp_err, read_data, last_err, last_data);
            end
        end
    end

    initial begin
        // Reset state and clear length
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_data", read_data, 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        reset = 1'b0;
        count_clear("clear_cycles");
        issue(1, 0, 32'h3C, 0, STORE_W, LOAD_W, 1, 0, 32'h0000_0000);

        // Word/byte/half loads of a stored word
        issue(0, 1, 32'h10, 32'h80FF_7F01, STORE_W, LOAD_W, 1, 0, 32'h0);
        issue(1, 0, 32'h10, 0, STORE_W, LOAD_W,  1, 0, 32'h80FF_7F01);
        issue(1, 0, 32'h10, 0, STORE_W, LOAD_B,  1, 0, 32'hFFFF_FF80);
        issue(1, 0, 32'h10, 0, STORE_W, LOAD_BU, 1, 0, 32'h0000_0080);
        issue(1, 0, 32'h12, 0, STORE_W, LOAD_H,  1, 0, 32'h0000_7F01);
        issue(1, 0, 32'h10, 0, STORE_W, LOAD_HU, 1, 0, 32'h0000_80FF);

        // Partial stores
        issue(0, 1, 32'h06, 32'hABCD_1234, STORE_H, LOAD_W, 1, 0, 32'h0);
        issue(1, 0, 32'h04, 0, STORE_W, LOAD_W, 1, 0, 32'h0000_1234);
        issue(0, 1, 32'h07, 32'h0000_005A, STORE_B, LOAD_W, 1, 0, 32'h0);
        issue(1, 0, 32'h04, 0, STORE_W, LOAD_W, 1, 0, 32'h0000_125A);
        idle();

        // Faults leave memory untouched
        issue(0, 1, 32'h02, 32'hDEAD_BEEF, STORE_W, LOAD_W, 1, 1, 32'h0);
        issue(1, 0, 32'h01, 0, STORE_W, LOAD_H, 1, 1, 32'h0);
        issue(1, 0, 32'(DEPTH), 0, STORE_W, LOAD_W, 1, 1, 32'h0);
        issue(1, 1, 32'h00, 32'h1, STORE_W, LOAD_W, 1, 1, 32'h0);
        issue(1, 0, 32'h00, 0, STORE_W, LOAD_W, 1, 0, 32'h0000_0000);
        issue(0, 0, 32'h00, 0, STORE_W, LOAD_W, 1, 0, 32'h0);
        idle();

        // Back-to-back throughput
        issue(0, 1, 32'h20, 32'h1357_9BDF, STORE_W, LOAD_W, 1, 0, 32'h0);
        check("b2b_valid0", 32'(resp_valid), 32'd1);
        issue(1, 0, 32'h20, 0, STORE_W, LOAD_W, 1, 0, 32'h1357_9BDF);
        check("b2b_valid1", 32'(resp_valid), 32'd1);
        issue(1, 0, 32'h20, 0, STORE_W, LOAD_W, 1, 0, 32'h1357_9BDF);
        check("b2b_valid2", 32'(resp_valid), 32'd1);
        idle();
        idle();

        // Reset drops an in-flight response, then restarts the clear mid-way
        issue(1, 0, 32'h20, 0, STORE_W, LOAD_W, 1, 0, 32'h0);
        reset = 1'b1;
        req_valid = 1'b0; memread = 1'b0; memwrite = 1'b0;
        #1;
        check("drop_valid", 32'(resp_valid), 32'd0);
        exp_q.delete();
        @(posedge CLK); #1;
        reset = 1'b0;
        repeat (5) begin @(posedge CLK); #1; end
        reset = 1'b1;
        @(posedge CLK); #1;
        check("midclr_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        count_clear("clear_restart");
        issue(1, 0, 32'h20, 0, STORE_W, LOAD_W, 1, 0, 32'h0000_0000);

        // Random traffic against the reference model
        for (int t = 0; t < 400; t++) begin
            int          kind;
            logic [31:0] a;
            logic [1:0]  sop;
            logic [2:0]  lop;
            kind = int'($urandom_range(0, 19));
            a    = 32'($urandom_range(0, DEPTH + 7));
            if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
            sop  = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            case ($urandom_range(0, 11))
                0, 1:    lop = LOAD_B;
                2, 3:    lop = LOAD_H;
                4, 5:    lop = LOAD_W;
                6, 7:    lop = LOAD_BU;
                8, 9:    lop = LOAD_HU;
                default: lop = 3'($urandom_range(0, 7));
            endcase
            if (kind < 2)       idle();
            else if (kind < 10) issue(0, 1, a, $urandom, sop, lop, 0, 0, 0);
            else if (kind < 18) issue(1, 0, a, $urandom, sop, lop, 0, 0, 0);
            else if (kind < 19) issue(1, 1, a, $urandom, sop, lop, 0, 0, 0);
            else                issue(0, 0, a, $urandom, sop, lop, 0, 0, 0);
        end
        idle();

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(posedge CLK); #1;
        end
        check("pending_resp", 32'(exp_q.size()), 32'd0);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
